// File: rtl/song_draw_pkg.sv
// Shared state encoding and play-field geometry for the note-highway controller.
package song_draw_pkg;

  typedef enum logic [3:0] {
    IDLE,
    CLEAR,
    CLEAR_DRAIN,
    WAIT_BEAT,
    SHIFT,
    BOX_SETUP,
    DRAW,
    DRAW_DRAIN,
    DONE
  } state_t;

  localparam int unsigned FIELD_W   = 240;
  localparam int unsigned FIELD_H   = 180;
  localparam int unsigned BOX_W     = 30;
  localparam int unsigned BOX_H     = 60;
  localparam int unsigned NUM_BOXES = 12;

endpackage

// File: rtl/valid_delay.sv
// Fixed-depth shift register that delays a valid strobe to match datapath latency.
module valid_delay #(
  parameter int unsigned DEPTH = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic in,
  output logic out
);

  logic [DEPTH-1:0] pipe;

  always_ff @(posedge clock) begin
    if (reset) begin
      pipe <= '0;
    end else begin
      pipe[0] <= in;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        pipe[i] <= pipe[i-1];
      end
    end
  end

  assign out = pipe[DEPTH-1];

endmodule

// File: rtl/song_draw_control.sv
// Control FSM for the note-highway datapath: field clear, per-beat lane shift, box redraw.
module song_draw_control
  import song_draw_pkg::*;
#(
  parameter int unsigned BEAT_CYCLES = 1000000,
  parameter int unsigned SONG_STEPS  = 112,
  parameter int unsigned CLEAR_DELAY = 2,
  parameter int unsigned DRAW_DELAY  = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        shiftSong,
  output logic        loadDefault,
  output logic        writeDefault,
  output logic        loadX,
  output logic        loadY,
  output logic        loadStartAddress,
  output logic        writeToScreen,
  output logic        songDone,
  output logic [15:0] gridCounter,
  output logic [3:0]  boxCounter,
  output logic [14:0] pixelCount,
  output logic        plot,
  output logic        busy
);

  state_t      state, nextState;
  logic [7:0]  gridX, gridY;
  logic [7:0]  pixX;
  logic [6:0]  pixY;
  logic [3:0]  boxCount;
  logic [31:0] beatCount;
  logic [15:0] stepCount;
  logic [15:0] drainCount;
  logic        clearIssue, drawIssue, clearPlot, drawPlot;

  logic clearLast, boxLast, lastBox, clearDrainLast, drawDrainLast, beatDue, songEnd;

  assign clearLast      = (gridX == 8'(FIELD_W - 1)) && (gridY == 8'(FIELD_H - 1));
  assign boxLast        = (pixX == 8'(BOX_W - 1)) && (pixY == 7'(BOX_H - 1));
  assign lastBox        = (boxCount == 4'(NUM_BOXES));
  assign clearDrainLast = (drainCount == 16'(CLEAR_DELAY - 1));
  assign drawDrainLast  = (drainCount == 16'(DRAW_DELAY - 1));
  assign beatDue        = (beatCount >= 32'(BEAT_CYCLES - 1));
  assign songEnd        = (stepCount == 16'(SONG_STEPS));

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:        if (start) nextState = CLEAR;
      CLEAR:       if (clearLast) nextState = CLEAR_DRAIN;
      CLEAR_DRAIN: if (clearDrainLast) nextState = SHIFT;
      WAIT_BEAT:   if (beatDue) nextState = SHIFT;
      SHIFT:       nextState = BOX_SETUP;
      BOX_SETUP:   nextState = DRAW;
      DRAW:        if (boxLast) nextState = lastBox ? DRAW_DRAIN : BOX_SETUP;
      DRAW_DRAIN:  if (drawDrainLast) nextState = songEnd ? DONE : WAIT_BEAT;
      DONE:        if (start) nextState = CLEAR;
      default:     nextState = IDLE;
    endcase
  end

  always_comb begin
    shiftSong        = 1'b0;
    loadDefault      = 1'b0;
    writeDefault     = 1'b0;
    loadX            = 1'b0;
    loadStartAddress = 1'b0;
    writeToScreen    = 1'b0;
    songDone         = 1'b0;
    busy             = 1'b1;
    clearIssue       = 1'b0;
    drawIssue        = 1'b0;
    case (state)
      IDLE:        busy = 1'b0;
      CLEAR:       begin loadDefault = 1'b1; writeDefault = 1'b1; clearIssue = 1'b1; end
      CLEAR_DRAIN: writeDefault = 1'b1;
      SHIFT:       shiftSong = 1'b1;
      BOX_SETUP:   begin loadStartAddress = 1'b1; writeToScreen = 1'b1; end
      DRAW:        begin loadX = 1'b1; writeToScreen = 1'b1; drawIssue = 1'b1; end
      DRAW_DRAIN:  begin loadX = 1'b1; writeToScreen = 1'b1; end
      DONE:        begin songDone = 1'b1; busy = 1'b0; end
      default:     ;
    endcase
  end

  assign loadY = loadX;

  // beatCount reads 0 during the SHIFT cycle itself, so it is reloaded with 1 for the cycle after.
  always_ff @(posedge clock) begin
    if (reset) begin
      gridX      <= '0;
      gridY      <= '0;
      pixX       <= '0;
      pixY       <= '0;
      boxCount   <= '0;
      beatCount  <= '0;
      stepCount  <= '0;
      drainCount <= '0;
    end else begin
      drainCount <= ((state == CLEAR_DRAIN && !clearDrainLast) ||
                     (state == DRAW_DRAIN && !drawDrainLast)) ? drainCount + 16'd1 : '0;

      if (state == SHIFT)            beatCount <= 32'd1;
      else if (state == CLEAR_DRAIN) beatCount <= '0;
      else if (beatCount != '1)      beatCount <= beatCount + 32'd1;

      if (state == CLEAR_DRAIN) stepCount <= '0;
      else if (state == SHIFT)  stepCount <= stepCount + 16'd1;

      if ((state == IDLE || state == DONE) && start) begin
        gridX <= '0;
        gridY <= '0;
      end else if (state == CLEAR && !clearLast) begin
        if (gridY == 8'(FIELD_H - 1)) begin
          gridY <= '0;
          gridX <= gridX + 8'd1;
        end else begin
          gridY <= gridY + 8'd1;
        end
      end

      case (state)
        SHIFT: begin
          boxCount <= 4'd1;
          pixX     <= '0;
          pixY     <= '0;
        end
        DRAW: begin
          if (boxLast) begin
            if (!lastBox) begin
              boxCount <= boxCount + 4'd1;
              pixX     <= '0;
              pixY     <= '0;
            end
          end else if (pixY == 7'(BOX_H - 1)) begin
            pixY <= '0;
            pixX <= pixX + 8'd1;
          end else begin
            pixY <= pixY + 7'd1;
          end
        end
        DRAW_DRAIN: begin
          if (drawDrainLast) begin
            boxCount <= '0;
            pixX     <= '0;
            pixY     <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign gridCounter = {gridX, gridY};
  assign pixelCount  = {pixX, pixY};
  assign boxCounter  = boxCount;

  valid_delay #(.DEPTH(CLEAR_DELAY)) clearDelay (
    .clock (clock),
    .reset (reset),
    .in    (clearIssue),
    .out   (clearPlot)
  );

  valid_delay #(.DEPTH(DRAW_DELAY)) drawDelay (
    .clock (clock),
    .reset (reset),
    .in    (drawIssue),
    .out   (drawPlot)
  );

  assign plot = clearPlot | drawPlot;

endmodule

// File: tb/tb_song_draw_control.sv
// Directed bench: two controllers share a clock, one with a short beat and short song, one with a long beat.
module tb_song_draw_control;

  logic clock, resetA, resetB, startA, startB;

  logic        shiftSongA, loadDefaultA, writeDefaultA, loadXA, loadYA, loadStartAddressA;
  logic        writeToScreenA, songDoneA, plotA, busyA;
  logic [15:0] gridCounterA;
  logic [3:0]  boxCounterA;
  logic [14:0] pixelCountA;

  logic        shiftSongB, loadDefaultB, writeDefaultB, loadXB, loadYB, loadStartAddressB;
  logic        writeToScreenB, songDoneB, plotB, busyB;
  logic [15:0] gridCounterB;
  logic [3:0]  boxCounterB;
  logic [14:0] pixelCountB;

  song_draw_control #(.BEAT_CYCLES(10), .SONG_STEPS(2), .CLEAR_DELAY(2), .DRAW_DELAY(3)) dutA (
    .clock(clock), .reset(resetA), .start(startA),
    .shiftSong(shiftSongA), .loadDefault(loadDefaultA), .writeDefault(writeDefaultA),
    .loadX(loadXA), .loadY(loadYA), .loadStartAddress(loadStartAddressA),
    .writeToScreen(writeToScreenA), .songDone(songDoneA), .gridCounter(gridCounterA),
    .boxCounter(boxCounterA), .pixelCount(pixelCountA), .plot(plotA), .busy(busyA)
  );

  song_draw_control #(.BEAT_CYCLES(30000), .SONG_STEPS(100), .CLEAR_DELAY(2), .DRAW_DELAY(3)) dutB (
    .clock(clock), .reset(resetB), .start(startB),
    .shiftSong(shiftSongB), .loadDefault(loadDefaultB), .writeDefault(writeDefaultB),
    .loadX(loadXB), .loadY(loadYB), .loadStartAddress(loadStartAddressB),
    .writeToScreen(writeToScreenB), .songDone(songDoneB), .gridCounter(gridCounterB),
    .boxCounter(boxCounterB), .pixelCount(pixelCountB), .plot(plotB), .busy(busyB)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int unsigned errors = 0, checks = 0;
  int unsigned cyc = 0;
  int unsigned ldCountA = 0, firstLdA = 0, lastLdA = 0, gridErrA = 0, firstPlotA = 0;
  int unsigned plotRunA = 0, setupsA = 0, setupsSinceShiftA = 0, curBoxA = 0;
  int unsigned boxErrA = 0, gapErrA = 0, lastSetupA = 0, lastShiftA = 0;
  int unsigned plotAfterResetB = 0;
  logic        trackB = 1'b0;
  logic [15:0] lastGridA = '0, expGrid;
  logic [14:0] pixMaxA = '0;
  int unsigned shiftCycA[$], shiftCycB[$], plotRunsA[$];
  int unsigned s0, s1, b0, b1, r0, r1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock, sampled 1 time unit after the edge, accumulating per-cycle observations.
  task automatic tick();
    @(posedge clock);
    #1;
    cyc++;
    if (loadDefaultA) begin
      if (ldCountA == 0) firstLdA = cyc;
      expGrid = {8'(ldCountA / 180), 8'(ldCountA % 180)};
      if (gridCounterA !== expGrid) gridErrA++;
      ldCountA++;
      lastLdA   = cyc;
      lastGridA = gridCounterA;
    end
    if (plotA && firstPlotA == 0) firstPlotA = cyc;
    if (shiftSongA) begin
      shiftCycA.push_back(cyc);
      plotRunsA.push_back(plotRunA);
      plotRunA          = 0;
      setupsSinceShiftA = 0;
      curBoxA           = 0;
      lastShiftA        = cyc;
    end
    if (plotA) plotRunA++;
    if (loadStartAddressA) begin
      setupsA++;
      setupsSinceShiftA++;
      curBoxA    = setupsSinceShiftA;
      lastSetupA = cyc;
      if (boxCounterA !== 4'(curBoxA) || pixelCountA !== 15'd0) boxErrA++;
    end else if (loadXA) begin
      if (boxCounterA !== 4'(curBoxA) || loadYA !== 1'b1) boxErrA++;
      if (pixelCountA > pixMaxA) pixMaxA = pixelCountA;
    end else if (boxCounterA !== 4'd0) begin
      boxErrA++;
    end
    if (plotA && ((lastSetupA != 0 && cyc == lastSetupA + 3) ||
                  (lastShiftA != 0 && cyc > lastShiftA && cyc <= lastShiftA + 4)))
      gapErrA++;
    if (shiftSongB) shiftCycB.push_back(cyc);
    if (trackB && plotB) plotAfterResetB++;
  endtask

  initial begin
    resetA = 1'b1; resetB = 1'b1; startA = 1'b1; startB = 1'b1;
    repeat (3) tick();
    check("resetOutputsA", {shiftSongA, loadDefaultA, writeDefaultA, loadXA, loadYA, loadStartAddressA,
          writeToScreenA, songDoneA, gridCounterA, boxCounterA, pixelCountA, plotA, busyA}, 64'd0);
    check("resetOutputsB", {shiftSongB, loadDefaultB, writeDefaultB, loadXB, loadYB, loadStartAddressB,
          writeToScreenB, songDoneB, gridCounterB, boxCounterB, pixelCountB, plotB, busyB}, 64'd0);

    resetA = 1'b0; resetB = 1'b0; startA = 1'b0; startB = 1'b0;
    tick();
    check("startInResetIgnored", {busyA, loadDefaultA, songDoneA}, 64'd0);

    startA = 1'b1; startB = 1'b1;
    cyc = 0;
    tick();
    startA = 1'b0; startB = 1'b0;
    check("clearEntry", {loadDefaultA, busyA, gridCounterA}, {2'b11, 16'h0000});

    while (cyc < 84500) tick();

    check("clearCycles", ldCountA, 43200);
    check("firstLoadDefault", firstLdA, 1);
    check("lastLoadDefault", lastLdA, 43200);
    check("lastGrid", lastGridA, 16'hEFB3);
    check("gridSequence", gridErrA, 0);
    check("firstClearPlot", firstPlotA, 3);
    s0 = (shiftCycA.size() > 0) ? shiftCycA[0] : 0;
    s1 = (shiftCycA.size() > 1) ? shiftCycA[1] : 0;
    b0 = (shiftCycB.size() > 0) ? shiftCycB[0] : 0;
    b1 = (shiftCycB.size() > 1) ? shiftCycB[1] : 0;
    r0 = (plotRunsA.size() > 0) ? plotRunsA[0] : 0;
    r1 = (plotRunsA.size() > 1) ? plotRunsA[1] : 0;
    check("firstShiftCycle", s0, 43203);
    check("clearPlotCount", r0, 43200);
    check("shortBeatSpacing", s1 - s0, 21617);
    check("redraw1PlotCount", r1, 21600);
    check("longBeatFirstShift", b0, 43203);
    check("longBeatSpacing", b1 - b0, 30000);
    check("midDrawBoxB", {busyB, writeToScreenB, boxCounterB}, {2'b11, 4'd7});

    resetB = 1'b1;
    tick();
    resetB = 1'b0;
    check("midDrawResetB", {busyB, plotB, loadXB, writeToScreenB, boxCounterB, pixelCountB}, 64'd0);
    trackB = 1'b1;

    while (!songDoneA && cyc < 87000) tick();

    check("songDoneA", {songDoneA, busyA}, 2'b10);
    check("songDoneCycle", cyc, 86436);
    check("shiftPulseCount", shiftCycA.size(), 2);
    check("redraw2PlotCount", plotRunA, 21600);
    check("setupCount", setupsA, 24);
    check("boxSequence", boxErrA, 0);
    check("pixelMax", pixMaxA, 15'h0EBB);
    check("plotGapAfterSetup", gapErrA, 0);
    check("noPlotAfterResetB", plotAfterResetB, 0);
    check("idleAfterResetB", {busyB, songDoneB}, 2'b00);

    startA = 1'b1;
    tick();
    startA = 1'b0;
    check("restartClear", {loadDefaultA, busyA, songDoneA, gridCounterA}, {3'b110, 16'h0000});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
